// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: queued prediction entry, FSM states
// and the direction/target mispredict test applied to the head entry.
package branch_resolver_pkg;

  localparam int ENTRY_XLEN = 32;

  typedef struct packed {
    logic                  taken;
    logic [ENTRY_XLEN-1:0] target;
    logic [ENTRY_XLEN-1:0] fallthru;
  } entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FLUSH  = 1'b1
  } state_e;

  // A taken/taken pair only mispredicts when the computed target differs.
  function automatic logic is_mispredict(input entry_t                head,
                                         input logic                  res_taken,
                                         input logic [ENTRY_XLEN-1:0] res_target);
    return (res_taken != head.taken) ||
           (res_taken && head.taken && (res_target != head.target));
  endfunction

endpackage

// File: rtl/branch_queue.sv
// In-order FIFO of in-flight predictions with push, pop and a clear that wins
// over both. Pointers wrap naturally; occupancy is tracked separately.
module branch_queue #(
  parameter  int DEPTH = 4,
  parameter  int W     = 65,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/branch_resolver.sv
// Checks fetch-time predictions against EX outcomes, oldest first; on a
// mispredict it pulses redirect/flush for one cycle and spends one FLUSH cycle.
//
// Handshakes: a prediction transfers on a cycle where pred_valid && pred_ready;
// a resolution is accepted whenever res_valid is high in NORMAL with a non-empty
// queue. Neither side may retract information once presented for its cycle.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int XLEN  = ENTRY_XLEN,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  input  logic [XLEN-1:0] pred_fallthru,
  output logic            pred_ready,
  input  logic            res_valid,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            upd_valid,
  output logic            upd_taken,
  output logic [CW-1:0]   inflight,
  output logic [31:0]     mispredict_count,
  output logic            err_underflow
);

  state_e          state_q, state_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            flush_q, flush_d;
  logic            upd_valid_q, upd_valid_d;
  logic            upd_taken_q, upd_taken_d;
  logic [31:0]     mispredict_count_q, mispredict_count_d;
  logic            err_underflow_q, err_underflow_d;

  logic            q_push, q_pop, q_clear, q_full, q_empty;
  logic [CW-1:0]   q_count;
  entry_t          wr_entry, head;
  logic [$bits(entry_t)-1:0] q_rdata;

  assign wr_entry = '{taken: pred_taken, target: pred_target, fallthru: pred_fallthru};
  assign head     = entry_t'(q_rdata);

  branch_queue #(.DEPTH(DEPTH), .W($bits(entry_t))) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .clear (q_clear),
    .wdata (wr_entry),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign pred_ready = (state_q == NORMAL) && !q_full;

  always_comb begin
    state_d            = state_q;
    redirect_valid_d   = 1'b0;
    redirect_pc_d      = redirect_pc_q;
    flush_d            = 1'b0;
    upd_valid_d        = 1'b0;
    upd_taken_d        = upd_taken_q;
    mispredict_count_d = mispredict_count_q;
    err_underflow_d    = err_underflow_q;
    q_pop              = 1'b0;
    q_clear            = 1'b0;
    case (state_q)
      NORMAL: begin
        if (res_valid) begin
          if (q_empty) begin
            err_underflow_d = 1'b1;
          end else begin
            upd_valid_d = 1'b1;
            upd_taken_d = res_taken;
            if (is_mispredict(head, res_taken, res_target)) begin
              state_d          = FLUSH;
              redirect_valid_d = 1'b1;
              flush_d          = 1'b1;
              redirect_pc_d    = res_taken ? res_target : head.fallthru;
              q_clear          = 1'b1;
              if (mispredict_count_q != 32'hFFFF_FFFF) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
              end
            end else begin
              q_pop = 1'b1;
            end
          end
        end
      end
      FLUSH: begin
        state_d = NORMAL;
      end
      default: begin
        state_d = NORMAL;
      end
    endcase
    // A push racing a mispredicting pop is on the wrong path.
    q_push = pred_valid && pred_ready && !q_clear;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= NORMAL;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      flush_q            <= 1'b0;
      upd_valid_q        <= 1'b0;
      upd_taken_q        <= 1'b0;
      mispredict_count_q <= '0;
      err_underflow_q    <= 1'b0;
    end else begin
      state_q            <= state_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      flush_q            <= flush_d;
      upd_valid_q        <= upd_valid_d;
      upd_taken_q        <= upd_taken_d;
      mispredict_count_q <= mispredict_count_d;
      err_underflow_q    <= err_underflow_d;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush            = flush_q;
  assign upd_valid        = upd_valid_q;
  assign upd_taken        = upd_taken_q;
  assign inflight         = q_count;
  assign mispredict_count = mispredict_count_q;
  assign err_underflow    = err_underflow_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed and random stimulus for branch_resolver, checked every cycle against
// a queue-based model of in-flight predictions.
module tb_branch_resolver;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            pred_valid = 1'b0, pred_taken = 1'b0;
  logic [XLEN-1:0] pred_target = '0, pred_fallthru = '0;
  logic            pred_ready;
  logic            res_valid = 1'b0, res_taken = 1'b0;
  logic [XLEN-1:0] res_target = '0;
  logic            redirect_valid, flush, upd_valid, upd_taken, err_underflow;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   inflight;
  logic [31:0]     mispredict_count;

  branch_resolver #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk              (clk),
    .rst              (rst),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .pred_fallthru    (pred_fallthru),
    .pred_ready       (pred_ready),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .upd_valid        (upd_valid),
    .upd_taken        (upd_taken),
    .inflight         (inflight),
    .mispredict_count (mispredict_count),
    .err_underflow    (err_underflow)
  );

  // reference model
  typedef struct {
    bit        taken;
    bit [31:0] target;
    bit [31:0] fallthru;
  } m_entry_t;

  m_entry_t  model_q[$];
  bit        m_flush;
  bit        exp_ready, exp_rv, exp_fl, exp_uv, exp_ut, exp_err;
  bit [31:0] exp_pc, exp_cnt;
  int        checks = 0;
  int        errors = 0;
  bit        chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pred_ready", {31'd0, pred_ready}, {31'd0, exp_ready});
    check("inflight", 32'(inflight), model_q.size());
    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_rv});
    check("redirect_pc", redirect_pc, exp_pc);
    check("flush", {31'd0, flush}, {31'd0, exp_fl});
    check("upd_valid", {31'd0, upd_valid}, {31'd0, exp_uv});
    if (exp_uv) check("upd_taken", {31'd0, upd_taken}, {31'd0, exp_ut});
    check("mispredict_count", mispredict_count, exp_cnt);
    check("err_underflow", {31'd0, err_underflow}, {31'd0, exp_err});
  endtask

  task automatic model_step(input bit r, input bit pv, input m_entry_t pe,
                            input bit rv, input bit rt, input bit [31:0] rtg);
    bit       acc, mis;
    m_entry_t hd;
    mis = 1'b0;
    if (r) begin
      model_q.delete();
      exp_rv = 0; exp_fl = 0; exp_uv = 0; exp_ut = 0; exp_err = 0;
      exp_pc = 0; exp_cnt = 0;
    end else begin
      acc    = !m_flush && pv && (model_q.size() < DEPTH);
      exp_rv = 0; exp_fl = 0; exp_uv = 0;
      if (!m_flush && rv) begin
        if (model_q.size() == 0) begin
          exp_err = 1;
        end else begin
          hd     = model_q[0];
          exp_uv = 1;
          exp_ut = rt;
          mis    = (rt != hd.taken) || (rt && hd.taken && rtg != hd.target);
          if (mis) begin
            exp_rv = 1;
            exp_fl = 1;
            exp_pc = rt ? rtg : hd.fallthru;
            if (exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
            model_q.delete();
            acc = 0;
          end else begin
            void'(model_q.pop_front());
          end
        end
      end
      if (acc) model_q.push_back(pe);
    end
    m_flush   = mis;
    exp_ready = !m_flush && (model_q.size() < DEPTH);
  endtask

  // driver: check the state left by the previous edge, then drive one cycle
  task automatic step(input bit r, input bit pv, input bit pt, input bit [31:0] ptg,
                      input bit [31:0] pft, input bit rv, input bit rt, input bit [31:0] rtg);
    m_entry_t pe;
    @(negedge clk);
    if (chk_en) check_all();
    rst = r; pred_valid = pv; pred_taken = pt; pred_target = ptg; pred_fallthru = pft;
    res_valid = rv; res_taken = rt; res_target = rtg;
    pe = '{taken: pt, target: ptg, fallthru: pft};
    model_step(r, pv, pe, rv, rt, rtg);
    @(posedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input bit pt, input bit [31:0] ptg, input bit [31:0] pft);
    step(0, 1, pt, ptg, pft, 0, 0, 0);
  endtask

  task automatic resolve(input bit rt, input bit [31:0] rtg);
    step(0, 0, 0, 0, 0, 1, rt, rtg);
  endtask

  // correct resolution of the model head, optionally with a new push
  task automatic push_res_good(input bit pv, input bit [31:0] tag);
    bit        rt;
    bit [31:0] rtg;
    rt  = (model_q.size() != 0) ? model_q[0].taken : 1'b0;
    rtg = (model_q.size() != 0) ? model_q[0].target : 32'd0;
    step(0, pv, tag[0], 32'h1000 + tag * 8, 32'h2000 + tag * 8, 1, rt, rtg);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    idle();

    // fill, then a fifth push must be refused
    for (int i = 0; i < 4; i++) push(i[0], 32'h800 + i * 16, 32'h804 + i * 16);
    push(1, 32'hDEAD, 32'hBEEF);
    idle();
    for (int i = 0; i < 4; i++) push_res_good(0, 0);
    idle();

    // correct not-taken
    push(0, 32'h0, 32'h104);
    resolve(0, 32'h0);
    idle();

    // direction mispredict with a younger entry behind it
    push(0, 32'h0, 32'h204);
    push(1, 32'h280, 32'h284);
    resolve(1, 32'h300);
    idle();
    idle();

    // target mispredict, then taken-predicted resolved not-taken
    push(1, 32'h400, 32'h404);
    resolve(1, 32'h480);
    idle();
    idle();
    push(1, 32'h500, 32'h504);
    resolve(0, 32'h0);
    idle();
    idle();

    // underflow is sticky and produces no pulses
    resolve(1, 32'h600);
    idle();
    idle();

    // full queue with concurrent push/pop, pointer wrap, push-order popping
    for (int i = 0; i < 4; i++) push(1, 32'h3000 + i * 8, 32'h3004 + i * 8);
    for (int i = 0; i < 20; i++) push_res_good(1, 32'(i + 16));
    for (int i = 0; i < 4; i++) push_res_good(0, 0);
    idle();

    // push racing a mispredicting pop is discarded
    push(0, 32'h0, 32'h704);
    step(0, 1, 1, 32'h900, 32'h904, 1, 1, 32'h700);
    idle();
    idle();

    // reset asserted during the FLUSH cycle
    push(0, 32'h0, 32'hA04);
    resolve(1, 32'hA80);
    step(1, 1, 0, 0, 0, 1, 1, 0);
    idle();
    idle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit        pv, pt, rv, rt, r;
      bit [31:0] ptg, pft, rtg;
      r   = ($urandom_range(0, 99) == 0);
      pv  = ($urandom_range(0, 2) != 0);
      pt  = $urandom_range(0, 1);
      ptg = 32'h4000 + $urandom_range(0, 7) * 4;
      pft = 32'h5000 + $urandom_range(0, 255) * 4;
      rv  = ($urandom_range(0, 2) == 0);
      if (model_q.size() != 0 && $urandom_range(0, 3) != 0) begin
        rt  = model_q[0].taken;
        rtg = ($urandom_range(0, 4) != 0) ? model_q[0].target : 32'h4000 + $urandom_range(0, 7) * 4;
      end else begin
        rt  = $urandom_range(0, 1);
        rtg = 32'h4000 + $urandom_range(0, 7) * 4;
      end
      step(r, pv, pt, ptg, pft, rv, rt, rtg);
    end
    idle();
    @(negedge clk);
    check_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
